// File: rtl/i2c_pkg.sv
// Shared definitions for the sequenced I2C register-access master.
// State encoding, default SCL timing and the SDA acknowledge levels.
package i2c_pkg;

  localparam int unsigned HALF_PERIOD_DEF = 125;

  // ACK is the bus pulled low; NACK is the released (high) level.
  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_ADDR    = 4'd2,
    S_ACK_A   = 4'd3,
    S_REG     = 4'd4,
    S_ACK_R   = 4'd5,
    S_WDATA   = 4'd6,
    S_RDATA   = 4'd7,
    S_ACK_D   = 4'd8,
    S_STOP_LO = 4'd9,
    S_STOP_HI = 4'd10,
    S_DONE    = 4'd11
  } state_t;

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL half-period timer: emits tick at terminal count, toggles SCL on tick when
// enabled, and pulses o_fall during the first CLK cycle after SCL goes low.
module i2c_scl_gen import i2c_pkg::*; #(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic CLK,
  input  logic Reset,
  input  logic i_clr,
  input  logic i_toggle,
  output logic o_scl,
  output logic o_tick,
  output logic o_fall
);

  localparam logic [15:0] LP_TERM = 16'(HALF_PERIOD - 1);

  logic [15:0] r_timer;
  logic        r_scl;
  logic        r_fall;

  assign o_tick = !i_clr && (r_timer == LP_TERM);
  assign o_scl  = r_scl;
  assign o_fall = r_fall;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_timer <= '0;
      r_scl   <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_fall <= o_tick && i_toggle && r_scl;
      if (i_clr || o_tick) r_timer <= '0;
      else                 r_timer <= r_timer + 16'd1;
      if (i_clr)                    r_scl <= 1'b1;
      else if (o_tick && i_toggle)  r_scl <= ~r_scl;
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// I2C master issuing one register write or read per iStart request.
// Optional NACK abort is enabled by defining I2C_MSEQ_ACK_CHECK_EN.
module i2c_master_seq import i2c_pkg::*; #(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRW,
  input  logic [6:0] iDevId,
  input  logic [7:0] iRegAddr,
  input  logic [7:0] iWrData,
  input  logic       iSDA,
  output logic       SCL,
  output logic       oSDA,
  output logic       oBusy,
  output logic       oDone,
  output logic       oAckErr,
  output logic [7:0] oRdData
);

  state_t     r_state, w_state_next, w_ack_state;
  logic       r_sda, w_sda_next;
  logic [2:0] r_bitcnt, w_bitcnt_next;
  logic [7:0] r_rx, w_rx_next, r_rd_data, w_rd_next;
  logic [6:0] r_dev;
  logic       r_rw;
  logic [7:0] r_reg, r_wdata, w_tx_byte;
  logic       w_latch, w_toggle, w_tick, w_fall, w_scl, w_hi_tick;

  i2c_scl_gen #(.HALF_PERIOD(HALF_PERIOD)) u_scl (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_clr   (r_state == S_IDLE),
    .i_toggle(w_toggle),
    .o_scl   (w_scl),
    .o_tick  (w_tick),
    .o_fall  (w_fall)
  );

  assign SCL       = w_scl;
  assign oSDA      = r_sda;
  assign oBusy     = (r_state != S_IDLE);
  assign oDone     = (r_state == S_DONE);
  assign oRdData   = r_rd_data;
  assign w_hi_tick = w_tick && w_scl;

  assign w_tx_byte   = (r_state == S_ADDR) ? {r_dev, r_rw} :
                       (r_state == S_REG)  ? r_reg : r_wdata;
  assign w_ack_state = (r_state == S_ADDR) ? S_ACK_A :
                       (r_state == S_REG)  ? S_ACK_R : S_ACK_D;

`ifdef I2C_MSEQ_ACK_CHECK_EN
  logic r_ackerr, w_ackerr_next;
  assign oAckErr = r_ackerr;
`else
  assign oAckErr = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_sda_next    = r_sda;
    w_bitcnt_next = r_bitcnt;
    w_rx_next     = r_rx;
    w_rd_next     = r_rd_data;
    w_toggle      = 1'b1;
    w_latch       = 1'b0;
`ifdef I2C_MSEQ_ACK_CHECK_EN
    w_ackerr_next = r_ackerr;
`endif
    unique case (r_state)
      S_IDLE: if (iStart) begin
        w_latch      = 1'b1;
        w_sda_next   = SDA_ACK;
        w_state_next = S_START;
`ifdef I2C_MSEQ_ACK_CHECK_EN
        w_ackerr_next = 1'b0;
`endif
      end
      S_START: if (w_tick) begin
        w_bitcnt_next = 3'd7;
        w_state_next  = S_ADDR;
      end
      S_ADDR, S_REG, S_WDATA, S_RDATA: begin
        if (w_fall) w_sda_next = (r_state == S_RDATA) ? SDA_NACK : w_tx_byte[r_bitcnt];
        if (w_hi_tick) begin
          if (r_state == S_RDATA) w_rx_next = {r_rx[6:0], iSDA};
          if (r_bitcnt == 3'd0) w_state_next  = w_ack_state;
          else                  w_bitcnt_next = r_bitcnt - 3'd1;
        end
      end
      S_ACK_A, S_ACK_R, S_ACK_D: begin
        // Release for the slave's ACK; after a read the same level is the master NACK.
        if (w_fall) w_sda_next = SDA_NACK;
        if (w_hi_tick) begin
          w_bitcnt_next = 3'd7;
          if (r_state == S_ACK_A)      w_state_next = S_REG;
          else if (r_state == S_ACK_R) w_state_next = r_rw ? S_RDATA : S_WDATA;
          else begin
            w_state_next = S_STOP_LO;
            if (r_rw) w_rd_next = r_rx;
          end
`ifdef I2C_MSEQ_ACK_CHECK_EN
          if ((iSDA != SDA_ACK) && !((r_state == S_ACK_D) && r_rw)) begin
            w_ackerr_next = 1'b1;
            w_state_next  = S_STOP_LO;
          end
`endif
        end
      end
      S_STOP_LO: begin
        if (w_fall) w_sda_next = SDA_ACK;
        if (w_tick) w_state_next = S_STOP_HI;
      end
      S_STOP_HI: begin
        // r_sda doubles as the phase flag: low half first, then released half.
        w_toggle = 1'b0;
        if (w_tick) begin
          if (!r_sda) w_sda_next   = SDA_NACK;
          else        w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_toggle     = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_sda     <= 1'b1;
      r_bitcnt  <= 3'd7;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_dev     <= '0;
      r_rw      <= 1'b0;
      r_reg     <= '0;
      r_wdata   <= '0;
    end else begin
      r_sda     <= w_sda_next;
      r_bitcnt  <= w_bitcnt_next;
      r_rx      <= w_rx_next;
      r_rd_data <= w_rd_next;
      if (w_latch) begin
        r_dev   <= iDevId;
        r_rw    <= iRW;
        r_reg   <= iRegAddr;
        r_wdata <= iWrData;
      end
    end
  end

`ifdef I2C_MSEQ_ACK_CHECK_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_ackerr <= 1'b0;
    else       r_ackerr <= w_ackerr_next;
  end
`endif

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a bit-level slave model on the bus.
module tb_i2c_master_seq;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0, iRW = 1'b0;
  logic [6:0] iDevId = '0;
  logic [7:0] iRegAddr = '0, iWrData = '0;
  logic       SCL, oSDA, oBusy, oDone, oAckErr;
  logic [7:0] oRdData;
  logic       r_slave = 1'b1;
  logic       w_bus;

  int n_tests = 0, n_fail = 0;
  int nbits = 0, hi_rise = 0, hi_fall = 0, n_done = 0;
  int frame_base = 0, rise_base = 0, fall_base = 0, done_base = 0;
  logic bits [0:1023];
  logic mbits [0:1023];
  logic slave_nack_addr = 1'b0, slave_rd = 1'b0;
  logic [7:0] slave_rdbyte = 8'h00;

  assign w_bus = oSDA & r_slave;

  i2c_master_seq #(.HALF_PERIOD(4)) dut (
    .CLK(CLK), .Reset(Reset), .iStart(iStart), .iRW(iRW), .iDevId(iDevId),
    .iRegAddr(iRegAddr), .iWrData(iWrData), .iSDA(w_bus), .SCL(SCL), .oSDA(oSDA),
    .oBusy(oBusy), .oDone(oDone), .oAckErr(oAckErr), .oRdData(oRdData)
  );

  always #5 CLK = ~CLK;

  always @(posedge SCL) begin
    if (nbits < 1024) begin
      bits[nbits]  = w_bus;
      mbits[nbits] = oSDA;
    end
    nbits++;
  end

  function automatic logic slave_bit(input int idx);
    if (idx == 8)  return slave_nack_addr;
    if (idx == 17) return 1'b0;
    if (idx == 26) return slave_rd;
    if (slave_rd && idx >= 18 && idx <= 25) return slave_rdbyte[25 - idx];
    return 1'b1;
  endfunction

  always @(negedge SCL) r_slave = slave_bit(nbits - frame_base);

  always @(w_bus) begin
    if (SCL) begin
      if (w_bus) hi_rise++;
      else       hi_fall++;
    end
  end

  always @(posedge CLK) if (oDone) n_done++;

  function automatic logic [7:0] bus_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7 - j] = bits[frame_base + 9 * k + j];
    return b;
  endfunction

  task automatic mark_frame();
    frame_base = nbits;
    rise_base  = hi_rise;
    fall_base  = hi_fall;
    done_base  = n_done;
  endtask

  task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, output bit ok);
    @(negedge CLK);
    mark_frame();
    iRW = rw; iDevId = dev; iRegAddr = rg; iWrData = wd; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (!oBusy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    n_tests++; if (SCL !== 1'b1)     begin n_fail++; $display("FAIL reset_scl: got %b want 1", SCL); end
    n_tests++; if (oSDA !== 1'b1)    begin n_fail++; $display("FAIL reset_sda: got %b want 1", oSDA); end
    n_tests++; if (oBusy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    n_tests++; if (oDone !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", oDone); end
    n_tests++; if (oAckErr !== 1'b0) begin n_fail++; $display("FAIL reset_ackerr: got %b want 0", oAckErr); end
    n_tests++; if (oRdData !== 8'h00) begin n_fail++; $display("FAIL reset_rddata: got %h want 00", oRdData); end
  endtask

  task automatic test_write();
    bit ok;
    run_txn(1'b0, 7'd5, 8'h12, 8'hA5, ok);
    $display("[TB] write dev=05 reg=12 data=A5 bytes=%h %h %h done=%0d", bus_byte(0), bus_byte(1), bus_byte(2), n_done - done_base);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL write_timeout: busy still %b want 0", oBusy); end
    n_tests++; if (bus_byte(0) !== 8'h0A) begin n_fail++; $display("FAIL write_byte0: got %h want 0A", bus_byte(0)); end
    n_tests++; if (bus_byte(1) !== 8'h12) begin n_fail++; $display("FAIL write_byte1: got %h want 12", bus_byte(1)); end
    n_tests++; if (bus_byte(2) !== 8'hA5) begin n_fail++; $display("FAIL write_byte2: got %h want A5", bus_byte(2)); end
    n_tests++; if ({bits[frame_base + 8], bits[frame_base + 17], bits[frame_base + 26]} !== 3'b000)
      begin n_fail++; $display("FAIL write_acks: got %b%b%b want 000", bits[frame_base + 8], bits[frame_base + 17], bits[frame_base + 26]); end
    n_tests++; if (n_done - done_base !== 1) begin n_fail++; $display("FAIL write_done_cnt: got %0d want 1", n_done - done_base); end
    n_tests++; if (oAckErr !== 1'b0) begin n_fail++; $display("FAIL write_ackerr: got %b want 0", oAckErr); end
    n_tests++; if (nbits - frame_base !== 28) begin n_fail++; $display("FAIL write_scl_rises: got %0d want 28", nbits - frame_base); end
    n_tests++; if (hi_fall - fall_base !== 1) begin n_fail++; $display("FAIL write_sda_fall_scl_hi: got %0d want 1", hi_fall - fall_base); end
    n_tests++; if (hi_rise - rise_base !== 1) begin n_fail++; $display("FAIL write_sda_rise_scl_hi: got %0d want 1", hi_rise - rise_base); end
    n_tests++; if ({SCL, oSDA} !== 2'b11) begin n_fail++; $display("FAIL write_idle_bus: got %b%b want 11", SCL, oSDA); end
    n_tests++; if (oRdData !== 8'h00) begin n_fail++; $display("FAIL write_rddata_hold: got %h want 00", oRdData); end
  endtask

  task automatic test_read();
    bit ok;
    slave_rd = 1'b1; slave_rdbyte = 8'hF0;
    run_txn(1'b1, 7'd5, 8'h00, 8'h5A, ok);
    slave_rd = 1'b0;
    $display("[TB] read dev=05 reg=00 bytes=%h %h %h rd=%h", bus_byte(0), bus_byte(1), bus_byte(2), oRdData);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL read_timeout: busy still %b want 0", oBusy); end
    n_tests++; if (bus_byte(0) !== 8'h0B) begin n_fail++; $display("FAIL read_byte0: got %h want 0B", bus_byte(0)); end
    n_tests++; if (bus_byte(1) !== 8'h00) begin n_fail++; $display("FAIL read_byte1: got %h want 00", bus_byte(1)); end
    n_tests++; if (bus_byte(2) !== 8'hF0) begin n_fail++; $display("FAIL read_bus_byte2: got %h want F0", bus_byte(2)); end
    n_tests++; if (mbits[frame_base + 26] !== 1'b1) begin n_fail++; $display("FAIL read_master_nack: got %b want 1", mbits[frame_base + 26]); end
    n_tests++; if (oRdData !== 8'hF0) begin n_fail++; $display("FAIL read_rddata: got %h want F0", oRdData); end
    n_tests++; if (n_done - done_base !== 1) begin n_fail++; $display("FAIL read_done_cnt: got %0d want 1", n_done - done_base); end
    n_tests++; if (hi_fall - fall_base !== 1 || hi_rise - rise_base !== 1)
      begin n_fail++; $display("FAIL read_start_stop_edges: got fall=%0d rise=%0d want 1 1", hi_fall - fall_base, hi_rise - rise_base); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge CLK);
    mark_frame();
    iRW = 1'b0; iDevId = 7'h21; iRegAddr = 8'h34; iWrData = 8'h77; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    repeat (20) @(negedge CLK);
    iDevId = 7'h7F; iWrData = 8'h11; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (oDone) begin ok = 1'b1; break; end
    end
    iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    repeat (30) @(negedge CLK);
    $display("[TB] back_to_back bytes=%h %h %h done=%0d busy=%b", bus_byte(0), bus_byte(1), bus_byte(2), n_done - done_base, oBusy);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: no done pulse, want 1"); end
    n_tests++; if (n_done - done_base !== 1) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 1", n_done - done_base); end
    n_tests++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", oBusy); end
    n_tests++; if (bus_byte(0) !== 8'h42) begin n_fail++; $display("FAIL b2b_byte0: got %h want 42", bus_byte(0)); end
    n_tests++; if (bus_byte(2) !== 8'h77) begin n_fail++; $display("FAIL b2b_byte2: got %h want 77", bus_byte(2)); end
    n_tests++; if (oRdData !== 8'hF0) begin n_fail++; $display("FAIL b2b_rddata_hold: got %h want F0", oRdData); end
  endtask

  task automatic test_nack_addr();
    bit ok;
    slave_nack_addr = 1'b1;
    run_txn(1'b0, 7'd5, 8'h12, 8'hA5, ok);
    slave_nack_addr = 1'b0;
    $display("[TB] nack_addr rises=%0d ackerr=%b done=%0d", nbits - frame_base, oAckErr, n_done - done_base);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nack_timeout: busy still %b want 0", oBusy); end
    n_tests++; if (n_done - done_base !== 1) begin n_fail++; $display("FAIL nack_done_cnt: got %0d want 1", n_done - done_base); end
    n_tests++; if (hi_rise - rise_base !== 1) begin n_fail++; $display("FAIL nack_stop_edge: got %0d want 1", hi_rise - rise_base); end
`ifdef I2C_MSEQ_ACK_CHECK_EN
    n_tests++; if (oAckErr !== 1'b1) begin n_fail++; $display("FAIL nack_ackerr: got %b want 1", oAckErr); end
    n_tests++; if (nbits - frame_base !== 10) begin n_fail++; $display("FAIL nack_scl_rises: got %0d want 10", nbits - frame_base); end
`else
    n_tests++; if (oAckErr !== 1'b0) begin n_fail++; $display("FAIL nack_ackerr: got %b want 0", oAckErr); end
    n_tests++; if (nbits - frame_base !== 28) begin n_fail++; $display("FAIL nack_scl_rises: got %0d want 28", nbits - frame_base); end
    n_tests++; if (bus_byte(2) !== 8'hA5) begin n_fail++; $display("FAIL nack_byte2: got %h want A5", bus_byte(2)); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge CLK);
    mark_frame();
    iRW = 1'b0; iDevId = 7'd5; iRegAddr = 8'h12; iWrData = 8'hA5; iStart = 1'b1;
    @(negedge CLK);
    iStart = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if ((nbits - frame_base >= 13) && SCL == 1'b0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge CLK);
    n_tests++; if (!ok || {SCL, oSDA} !== 2'b00)
      begin n_fail++; $display("FAIL rstmid_pre: reached=%b scl/sda=%b%b want 1 00", ok, SCL, oSDA); end
    Reset = 1'b1;
    #1;
    n_tests++; if ({SCL, oSDA, oBusy} !== 3'b110)
      begin n_fail++; $display("FAIL rstmid_force: scl/sda/busy=%b%b%b want 110", SCL, oSDA, oBusy); end
    @(negedge CLK);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    run_txn(1'b0, 7'h33, 8'h5A, 8'h3C, ok);
    $display("[TB] post_reset write bytes=%h %h %h done=%0d", bus_byte(0), bus_byte(1), bus_byte(2), n_done - done_base);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: busy still %b want 0", oBusy); end
    n_tests++; if (bus_byte(0) !== 8'h66) begin n_fail++; $display("FAIL rstmid_byte0: got %h want 66", bus_byte(0)); end
    n_tests++; if (bus_byte(1) !== 8'h5A) begin n_fail++; $display("FAIL rstmid_byte1: got %h want 5A", bus_byte(1)); end
    n_tests++; if (bus_byte(2) !== 8'h3C) begin n_fail++; $display("FAIL rstmid_byte2: got %h want 3C", bus_byte(2)); end
    n_tests++; if (n_done - done_base !== 1) begin n_fail++; $display("FAIL rstmid_done_cnt: got %0d want 1", n_done - done_base); end
    n_tests++; if (oAckErr !== 1'b0) begin n_fail++; $display("FAIL rstmid_ackerr: got %b want 0", oAckErr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_nack_addr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
